adc_pixel_capture: RTL

//   Receive end of the ADC conversion-pulse interface. Watches the toggling start-conversion line

---
 rtl/adc_pixel_capture_pkg.sv | 15 +
 rtl/adc_pixel_capture_pixel_fifo.sv | 65 ++++++
 rtl/adc_pixel_capture.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/adc_pixel_capture_pkg.sv
// rtl/adc_pixel_capture_pkg.sv - shared defaults and FSM encoding for the ADC pixel capture block
package adc_pixel_capture_pkg;

  localparam int ADC_BITS_DEFAULT   = 12;
  localparam int NUM_PIXELS_DEFAULT = 2048;
  localparam int IDX_W_DEFAULT      = $clog2(NUM_PIXELS_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/adc_pixel_capture_pixel_fifo.sv
// rtl/adc_pixel_capture_pixel_fifo.sv - small synchronous FIFO with occupancy output and flush
module pixel_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             do_push;
  logic             do_pop;

  assign o_full      = (level == LVL_W'(DEPTH));
  assign o_empty     = (level == '0);
  assign o_level     = level;
  assign o_head_data = mem[rd_ptr];
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop      = i_pop && !o_empty;
  assign do_push     = i_push && (!o_full || do_pop);

  // Pointer and occupancy tracking; flush empties the queue without touching storage.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero until the first write.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !i_flush) begin
      mem[wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/adc_pixel_capture.sv
// rtl/adc_pixel_capture.sv - conversion-pulse edge detect, delayed data latch, line FSM and output FIFO
module adc_pixel_capture
  import adc_pixel_capture_pkg::*;
#(
  parameter int ADC_BITS         = ADC_BITS_DEFAULT,
  parameter int NUM_PIXELS       = NUM_PIXELS_DEFAULT,
  parameter int ADC_PIPE_LATENCY = 3,
  parameter int SAMPLE_DELAY     = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                            i_clock,
  input  logic                            i_reset_n,
  input  logic                            i_enable,
  input  logic                            i_adc_start_conversion,
  input  logic [ADC_BITS-1:0]             i_adc_data,
  output logic [ADC_BITS-1:0]             o_pixel_data,
  output logic [$clog2(NUM_PIXELS)-1:0]   o_pixel_index,
  output logic                            o_pixel_valid,
  input  logic                            i_pixel_ready,
  output logic                            o_frame_start,
  output logic                            o_frame_done,
  output logic                            o_overrun,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);
  localparam int IDX_W  = $clog2(NUM_PIXELS);
  localparam int FILL_W = (ADC_PIPE_LATENCY > 1) ? $clog2(ADC_PIPE_LATENCY) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST =
    FILL_W'((ADC_PIPE_LATENCY > 0) ? ADC_PIPE_LATENCY - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_PIXELS - 1);

  cap_state_t              state;
  logic                    start_d;
  logic                    rise;
  logic                    strobe;
  logic [SAMPLE_DELAY-1:0] dly;
  logic [SAMPLE_DELAY:0]   dly_next;
  logic [FILL_W-1:0]       fill_cnt;
  logic [IDX_W-1:0]        pixel_index;
  logic                    capture_strobe;
  logic                    pop;
  logic                    push_ok;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ADC_BITS+IDX_W-1:0] fifo_head;

  assign rise     = i_adc_start_conversion && !start_d;
  // Each rise travels its own slot so closely spaced rises all produce a strobe.
  assign dly_next = {dly, rise};
  assign strobe   = dly[SAMPLE_DELAY-1];

  assign o_pixel_valid  = !fifo_empty;
  assign pop            = o_pixel_valid && i_pixel_ready;
  assign capture_strobe = strobe && i_enable && (state == ST_CAPTURE);
  // A full FIFO still accepts the sample when the consumer takes the head in the same cycle.
  assign push_ok        = capture_strobe && (!fifo_full || pop);

  assign o_pixel_data  = fifo_head[ADC_BITS-1:0];
  assign o_pixel_index = fifo_head[ADC_BITS +: IDX_W];

  // Previous level of the conversion line for rising-edge detection.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) start_d <= 1'b0;
    else            start_d <= i_adc_start_conversion;
  end

  // Rise-to-strobe delay line, emptied whenever the frame is disabled.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)     dly <= '0;
    else if (!i_enable) dly <= '0;
    else                dly <= dly_next[SAMPLE_DELAY-1:0];
  end

  // Line FSM: skip pipeline-fill strobes, index captured pixels, stop after the last one.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      fill_cnt    <= '0;
      pixel_index <= '0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      if (!i_enable) begin
        state       <= ST_IDLE;
        fill_cnt    <= '0;
        pixel_index <= '0;
        o_overrun   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= (ADC_PIPE_LATENCY == 0) ? ST_CAPTURE : ST_FILL;
          end
          ST_FILL: begin
            if (strobe) begin
              if (fill_cnt == FILL_LAST) state <= ST_CAPTURE;
              else                       fill_cnt <= fill_cnt + FILL_W'(1);
            end
          end
          ST_CAPTURE: begin
            if (strobe) begin
              if (push_ok && (pixel_index == '0)) o_frame_start <= 1'b1;
              if (!push_ok)                       o_overrun     <= 1'b1;
              // The index advances even on a drop so later pixels keep their position.
              if (pixel_index == IDX_LAST) begin
                state        <= ST_DONE;
                o_frame_done <= 1'b1;
              end else begin
                pixel_index <= pixel_index + IDX_W'(1);
              end
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  pixel_fifo #(
    .WIDTH (ADC_BITS + IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pixel_fifo (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_flush     (!i_enable),
    .i_push      (push_ok),
    .i_push_data ({pixel_index, i_adc_data}),
    .i_pop       (pop),
    .o_head_data (fifo_head),
    .o_level     (o_fifo_level),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

endmodule
